aes_decryption: RTL and testbench

Iterative AES-128 decryption core that inverts the team's AES-128 encryption core. It executes one inverse round per clock and derives round keys on the fly: a forward pass reaches round key 10, then the inverse schedule walks back to round key 0. It has a start/done handshake and sits beside the encryption core, taking the same 128-bit cipher key.

---
 rtl/aes_pkg.sv | 103 ++++++++++
 rtl/aes_inv_round.sv | 49 ++++
 rtl/aes_decryption.sv | 116 +++++++++++
 tb/tb_aes_decryption.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state type, S-box tables, round constants,
// GF(2^8) arithmetic, word helpers, key-step functions and FSM states.
package aes_pkg;

  localparam int unsigned BLK_W  = 128;
  localparam int unsigned BYTE_W = 8;

  // Byte 0 sits in bits [127:120]; byte index = col*4 + row.
  typedef logic [0:15][BYTE_W-1:0] state_t;

  typedef enum logic [2:0] {IDLE, KEYFWD, INIT, ROUND, FINAL} fsm_e;

  localparam logic [0:255][7:0] SBOX = {
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

  localparam logic [0:255][7:0] INV_SBOX = {
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

  // Index 0 and 11..15 are padding so a 4-bit round counter never leaves the table.
  localparam logic [0:15][7:0] RCON = {
    8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
    8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00};

  // Column c of a state as a 32-bit word, row 0 in the top byte.
  function automatic logic [31:0] get_col(input state_t s, input logic [1:0] c);
    return {s[{c, 2'd0}], s[{c, 2'd1}], s[{c, 2'd2}], s[{c, 2'd3}]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = '0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  // rk(i-1) -> rk(i)
  function automatic logic [127:0] forward_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // rk(i) -> rk(i-1), rc being the constant that produced rk(i)
  function automatic logic [127:0] inverse_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] p0, p1, p2, p3;
    p3 = k[31:0]  ^ k[63:32];
    p2 = k[63:32] ^ k[95:64];
    p1 = k[95:64] ^ k[127:96];
    p0 = k[127:96] ^ sub_word(rot_word(p3)) ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last is set.
// Ports: st_in (state in), rk (round key), last (skip InvMixColumns), st_out.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_in,
  input  logic [127:0] rk,
  input  logic         last,
  output logic [127:0] st_out
);

  state_t      w_in;
  state_t      w_sb;
  state_t      w_ark;
  state_t      w_mix;
  logic [31:0] w_col;

  // Row r of output column c comes from input column (c - r) mod 4.
  always_comb begin
    w_in = st_in;
    w_sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sb[4'(c * 4 + r)] = INV_SBOX[w_in[4'(((c + 4 - r) % 4) * 4 + r)]];
      end
    end
    w_ark = w_sb ^ rk;
  end

  always_comb begin
    w_mix = '0;
    w_col = '0;
    for (int c = 0; c < 4; c++) begin
      w_col = get_col(w_ark, 2'(c));
      w_mix[4'(c * 4 + 0)] = gmul(w_col[31:24], 8'h0e) ^ gmul(w_col[23:16], 8'h0b) ^
                             gmul(w_col[15:8], 8'h0d)  ^ gmul(w_col[7:0], 8'h09);
      w_mix[4'(c * 4 + 1)] = gmul(w_col[31:24], 8'h09) ^ gmul(w_col[23:16], 8'h0e) ^
                             gmul(w_col[15:8], 8'h0b)  ^ gmul(w_col[7:0], 8'h0d);
      w_mix[4'(c * 4 + 2)] = gmul(w_col[31:24], 8'h0d) ^ gmul(w_col[23:16], 8'h09) ^
                             gmul(w_col[15:8], 8'h0e)  ^ gmul(w_col[7:0], 8'h0b);
      w_mix[4'(c * 4 + 3)] = gmul(w_col[31:24], 8'h0b) ^ gmul(w_col[23:16], 8'h0d) ^
                             gmul(w_col[15:8], 8'h09)  ^ gmul(w_col[7:0], 8'h0e);
    end
  end

  assign st_out = last ? w_ark : w_mix;

endmodule

// File: rtl/aes_decryption.sv
// Iterative AES-128 decryption core, one inverse round per clock, round keys
// derived on the fly (forward walk to rk10, then inverse walk back to rk0).
// Ports: clk, reset (sync, active-high), start, key, cipher in;
//        data (plaintext, registered), done (1-cycle pulse), busy out.
module aes_decryption
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] cipher,
  output logic [127:0] data,
  output logic         done,
  output logic         busy
);

  if (NR != 10) begin : g_bad_nr
    $error("aes_decryption: only NR = 10 (AES-128) is supported");
  end

  fsm_e         r_state;
  logic [3:0]   r_rnd;
  logic [127:0] r_st;
  logic [127:0] r_key;

  fsm_e         w_state_nxt;
  logic [3:0]   w_rnd_nxt;
  logic [127:0] w_st_nxt;
  logic [127:0] w_key_nxt;
  logic [127:0] w_data_nxt;
  logic         w_done_nxt;
  logic         w_busy_nxt;
  logic         w_last;
  logic [127:0] w_round_out;

  // Shared by ROUND (full inverse round) and FINAL (no InvMixColumns).
  assign w_last = (r_state == FINAL);

  aes_inv_round u_inv_round (
    .st_in  (r_st),
    .rk     (r_key),
    .last   (w_last),
    .st_out (w_round_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rnd   <= '0;
      r_st    <= '0;
      r_key   <= '0;
      data    <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_st    <= w_st_nxt;
      r_key   <= w_key_nxt;
      data    <= w_data_nxt;
      done    <= w_done_nxt;
      busy    <= w_busy_nxt;
    end
  end

  // Busy rises one cycle after the start is accepted and drops with done.
  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_st_nxt    = r_st;
    w_key_nxt   = r_key;
    w_data_nxt  = data;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_st_nxt    = cipher;
          w_key_nxt   = key;
          w_rnd_nxt   = 4'd1;
          w_state_nxt = KEYFWD;
        end
      end
      KEYFWD: begin
        w_busy_nxt = 1'b1;
        w_key_nxt  = forward_step(r_key, RCON[r_rnd]);
        w_rnd_nxt  = r_rnd + 4'd1;
        if (r_rnd == 4'(NR)) w_state_nxt = INIT;
      end
      INIT: begin
        w_busy_nxt  = 1'b1;
        w_st_nxt    = r_st ^ r_key;
        w_key_nxt   = inverse_step(r_key, RCON[4'(NR)]);
        w_rnd_nxt   = 4'(NR - 1);
        w_state_nxt = ROUND;
      end
      ROUND: begin
        w_busy_nxt = 1'b1;
        w_st_nxt   = w_round_out;
        w_key_nxt  = inverse_step(r_key, RCON[r_rnd]);
        w_rnd_nxt  = r_rnd - 4'd1;
        if (r_rnd == 4'd1) w_state_nxt = FINAL;
      end
      FINAL: begin
        w_data_nxt  = w_round_out;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_decryption.sv
// Scoreboard bench for aes_decryption: the driver pushes expected plaintext and
// done cycle, a negedge monitor pops and compares on every done pulse.
module tb_aes_decryption;

  logic         clk;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic [127:0] cipher;
  logic [127:0] data;
  logic         done;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] data;
    int           cyc;
    string        name;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tb_sbox[256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decryption #(.NR(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .key    (key),
    .cipher (cipher),
    .data   (data),
    .done   (done),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 128'(done), 128'(0));
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_data"}, data, e.data);
        check({e.name, "_done_cycle"}, 128'(cyc), 128'(e.cyc));
      end
    end
  end

  // Reference encryption with an S-box derived from GF inversion + affine map.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      tb_sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] m_encrypt(input logic [127:0] k, input logic [127:0] pt);
    logic [0:15][7:0] s;
    logic [0:15][7:0] t;
    logic [127:0]     rk;
    logic [31:0]      tw, n0, n1, n2, n3;
    logic [7:0]       rc, a0, a1, a2, a3;
    rk = k;
    s  = pt ^ rk;
    rc = 8'h01;
    for (int r = 1; r <= 10; r++) begin
      tw = {rk[23:0], rk[31:24]};
      tw = {tb_sbox[tw[31:24]], tb_sbox[tw[23:16]], tb_sbox[tw[15:8]], tb_sbox[tw[7:0]]} ^ {rc, 24'h0};
      n0 = rk[127:96] ^ tw;
      n1 = rk[95:64] ^ n0;
      n2 = rk[63:32] ^ n1;
      n3 = rk[31:0] ^ n2;
      rk = {n0, n1, n2, n3};
      rc = m_mul(rc, 8'h02);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[4'(c * 4 + w)] = tb_sbox[s[4'(((c + w) % 4) * 4 + w)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4'(c * 4)];
          a1 = t[4'(c * 4 + 1)];
          a2 = t[4'(c * 4 + 2)];
          a3 = t[4'(c * 4 + 3)];
          s[4'(c * 4)]     = m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3;
          s[4'(c * 4 + 1)] = a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3;
          s[4'(c * 4 + 2)] = a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03);
          s[4'(c * 4 + 3)] = m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02);
        end
      end else begin
        s = t;
      end
      s = s ^ rk;
    end
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns 1ns after that edge with key/cipher scrambled.
  task automatic issue(input logic [127:0] k, input logic [127:0] c, input logic [127:0] pt,
                       input bit want_done, input string nm);
    exp_t e;
    key    = k;
    cipher = c;
    start  = 1'b1;
    if (want_done) begin
      e.data = pt;
      e.cyc  = cyc + 22;
      e.name = nm;
      sb_q.push_back(e);
    end
    tick();
    start  = 1'b0;
    key    = rand128();
    cipher = rand128();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      check("done_timeout", 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] rk, rpt;
    reset  = 1'b1;
    start  = 1'b0;
    key    = '0;
    cipher = '0;
    build_sbox();
    repeat (3) tick();
    check("reset_data", data, 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    tick();

    // C.1 run, then B issued in the C.1 done cycle with busy profile.
    issue(C1_KEY, C1_CT, C1_PT, 1'b1, "c1");
    repeat (21) tick();
    issue(B_KEY, B_CT, B_PT, 1'b1, "b_backtoback");
    check("b_busy_k0", 128'(busy), 128'(0));
    for (int k = 1; k <= 21; k++) begin
      tick();
      check($sformatf("b_busy_k%0d", k), 128'(busy), 128'((k >= 1 && k <= 20) ? 1 : 0));
      if (k == 3) check("data_held_during_run", data, C1_PT);
      if (k == 5) begin
        start  = 1'b1;
        key    = rand128();
        cipher = rand128();
      end
      if (k == 6) start = 1'b0;
    end
    drain(5);
    repeat (30) tick();

    // Reset in the middle of a C.1 run aborts it silently.
    issue(C1_KEY, C1_CT, C1_PT, 1'b0, "c1_abort");
    repeat (11) tick();
    reset = 1'b1;
    tick();
    check("midreset_data", data, 128'(0));
    check("midreset_done", 128'(done), 128'(0));
    check("midreset_busy", 128'(busy), 128'(0));
    reset = 1'b0;
    repeat (25) tick();
    issue(C1_KEY, C1_CT, C1_PT, 1'b1, "c1_after_reset");
    drain(30);

    // Reset and start together: start must not be captured.
    reset  = 1'b1;
    start  = 1'b1;
    key    = B_KEY;
    cipher = B_CT;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    check("reset_start_busy", 128'(busy), 128'(0));
    repeat (25) tick();

    // Round trip against the reference encryption.
    for (int i = 0; i < 200; i++) begin
      rk  = rand128();
      rpt = rand128();
      issue(rk, m_encrypt(rk, rpt), rpt, 1'b1, $sformatf("roundtrip%0d", i));
      drain(30);
    end

    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
